// File: rtl/vcve2_pkg.sv
// rtl/vcve2_pkg.sv - shared constants for the vector core memory map
package vcve2_pkg;

    // Upper 23 bits of the 512-byte vector register file window (32-bit addresses).
    parameter logic [22:0] VRF_START_ADDR = 23'h0A_0000;

endpackage

// File: rtl/vcve2_vrf_mem.sv
// rtl/vcve2_vrf_mem.sv - OBI-style responder backing the vector register file window
module vcve2_vrf_mem #(
    parameter int unsigned               AddrWidth    = 32,
    parameter logic [AddrWidth-10:0]     VrfStartAddr = vcve2_pkg::VRF_START_ADDR
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          wdata_i,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_q [128];
    logic [31:0] mem_d [128];

    logic [6:0] idx;
    logic       hit;

    assign idx   = addr_i[8:2];
    assign hit   = (addr_i[AddrWidth-1:9] == VrfStartAddr) && (addr_i[1:0] == 2'b00);
    assign gnt_o = req_i & ~clear_i;

    always_comb begin
        mem_d   = mem_q;
        state_d = IDLE;
        err_d   = 1'b0;
        rdata_d = 32'h0;
        if (clear_i) begin
            for (int i = 0; i < 128; i++) begin
                mem_d[i] = 32'h0;
            end
        end else if (gnt_o) begin
            state_d = RESP;
            if (!hit) begin
                err_d = 1'b1;
            end else if (we_i) begin
                for (int k = 0; k < 4; k++) begin
                    if (be_i[k]) begin
                        mem_d[idx][8*k +: 8] = wdata_i[8*k +: 8];
                    end
                end
            end else begin
                // Reads never coincide with a write, so the stored word is already current.
                rdata_d = mem_q[idx];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            for (int i = 0; i < 128; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            for (int i = 0; i < 128; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rvalid_o = (state_q == RESP);
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_vcve2_vrf_mem.sv
// tb/tb_vcve2_vrf_mem.sv - randomized and directed checks against a word-array model
module tb_vcve2_vrf_mem;

    localparam logic [22:0] PFX = vcve2_pkg::VRF_START_ADDR;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        req_i = 1'b0;
    logic        gnt_o;
    logic [31:0] addr_i = 32'h0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = 4'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [128];
    logic        exp_valid = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_rdata = 32'h0;

    vcve2_vrf_mem dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (clear_i),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .addr_i   (addr_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .wdata_i  (wdata_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] vaddr(input int word);
        logic [6:0] w;
        w = 7'(word);
        return {PFX, w, 2'b00};
    endfunction

    task automatic model_zero();
        for (int i = 0; i < 128; i++) mem_m[i] = 32'h0;
    endtask

    // One bus cycle: check the response from the previous edge, drive, check grant, update model.
    task automatic cycle(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd, input logic clr,
                         input string tag);
        logic        acc, in_win;
        logic [31:0] mask;
        int          w;
        @(negedge clk_i);
        check({tag, ":rvalid"}, {31'h0, rvalid_o}, {31'h0, exp_valid});
        if (exp_valid) begin
            check({tag, ":err"}, {31'h0, err_o}, {31'h0, exp_err});
            check({tag, ":rdata"}, rdata_o, exp_rdata);
        end
        req_i = req; we_i = we; addr_i = addr; be_i = be; wdata_i = wd; clear_i = clr;
        #1;
        check({tag, ":gnt"}, {31'h0, gnt_o}, {31'h0, req & ~clr});
        acc       = req & ~clr;
        in_win    = (addr[31:9] == PFX) && (addr % 4 == 0);
        w         = int'(addr[8:2]);
        exp_valid = acc;
        exp_err   = acc & ~in_win;
        exp_rdata = 32'h0;
        if (clr) begin
            model_zero();
        end else if (acc && in_win) begin
            if (we) begin
                mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                mem_m[w] = (mem_m[w] & ~mask) | (wd & mask);
            end else begin
                exp_rdata = mem_m[w];
            end
        end
    endtask

    task automatic rd(input logic [31:0] a, input string tag);
        cycle(1'b1, 1'b0, a, 4'h0, 32'h0, 1'b0, tag);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d, input string tag);
        cycle(1'b1, 1'b1, a, be, d, 1'b0, tag);
    endtask

    task automatic idle(input string tag);
        cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, tag);
    endtask

    initial begin
        logic [31:0] a;
        model_zero();

        // Reset values and combinational grant while in reset
        #2;
        check("rst_rvalid", {31'h0, rvalid_o}, 32'h0);
        check("rst_err", {31'h0, err_o}, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        req_i = 1'b1;
        #1;
        check("rst_gnt", {31'h0, gnt_o}, 32'h1);
        req_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        rd(vaddr(31 * 4), "v31w0");
        idle("v31w0_resp");

        wr(vaddr(3 * 4 + 2), 4'hF, 32'hDEADBEEF, "wr_full");
        rd(vaddr(3 * 4 + 2), "raw_full");
        wr(vaddr(3 * 4 + 2), 4'b0101, 32'h11223344, "wr_part");
        rd(vaddr(3 * 4 + 2), "raw_part");

        rd({PFX + 23'd1, 9'h038}, "miss_pfx");
        rd(vaddr(3 * 4 + 2) | 32'h2, "miss_align");
        wr(vaddr(3 * 4 + 2) | 32'h1, 4'hF, 32'h0BADF00D, "miss_wr_align");
        wr({PFX - 23'd1, 9'h038}, 4'hF, 32'h0BADF00D, "miss_wr_pfx");
        rd(vaddr(3 * 4 + 2), "after_miss");

        for (int i = 0; i < 128; i++) wr(vaddr(i), 4'hF, 32'(i), "fill");
        for (int i = 0; i < 128; i++) rd(vaddr(i), "readback");

        // Clear while a request is presented, with a read still in flight
        rd(vaddr(77), "pre_clear");
        cycle(1'b1, 1'b0, vaddr(77), 4'h0, 32'h0, 1'b1, "clear");
        rd(vaddr(77), "post_clear");
        rd(vaddr(5), "post_clear2");

        // Randomized mix of reads, writes, misses and occasional clears
        for (int n = 0; n < 400; n++) begin
            a = vaddr(int'($urandom_range(0, 127)));
            case ($urandom_range(0, 15))
                0: a[31:9] = PFX ^ 23'($urandom_range(1, 255));
                1: a[1:0]  = 2'($urandom_range(1, 3));
                default: ;
            endcase
            cycle($urandom_range(0, 7) != 0, 1'($urandom), a, 4'($urandom), $urandom,
                  $urandom_range(0, 39) == 0, "rand");
        end

        // Reset mid-operation drops the pending response and wipes storage
        wr(vaddr(9), 4'hF, 32'hCAFEF00D, "pre_rst_wr");
        rd(vaddr(9), "pre_rst_rd");
        @(posedge clk_i);
        #1;
        check("pre_rst_valid", {31'h0, rvalid_o}, 32'h1);
        rst_ni = 1'b0;
        #1;
        check("rst_mid_rvalid", {31'h0, rvalid_o}, 32'h0);
        check("rst_mid_rdata", rdata_o, 32'h0);
        req_i = 1'b0;
        model_zero();
        exp_valid = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        rd(vaddr(9), "post_rst_rd");
        idle("drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vcve2_vrf_mem.md
# vcve2_vrf_mem

Memory-side responder for the vector register file region addressed by the vector AGU. It serves word requests on an OBI-style port (req/gnt/rvalid) and stores 32 vector registers of 128 bits each, as 128 flop-based 32-bit words. Its address window is the 512-byte region prefixed by `VRF_START_ADDR`. It decodes the AGU's byte address layout {prefix, vreg[4:0], word[1:0], 2'b00} and returns read data one cycle after grant.

## Interface
- `AddrWidth`, default 32: request address width; must be ≥ 10.
- `VrfStartAddr`, default `vcve2_pkg::VRF_START_ADDR`: region prefix, `AddrWidth-9` bits, compared against `addr_i[AddrWidth-1:9]`.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `clear_i`, in, 1: synchronous clear of all 128 storage words.
- `req_i`, in, 1: request valid.
- `gnt_o`, out, 1: request accepted this cycle.
- `addr_i`, in, AddrWidth: byte address.
- `we_i`, in, 1: 1 = write, 0 = read.
- `be_i`, in, 4: byte enables, used for writes.
- `wdata_i`, in, 32: write data.
- `rvalid_o`, out, 1: response valid.
- `rdata_o`, out, 32: read data; 0 for writes and errors.
- `err_o`, out, 1: error response, qualified by `rvalid_o`.

## Operation
- Storage: `mem[0..127]`, 32 bits each.
  - Word index = `addr_i[8:2]`.
  - vreg = `addr_i[8:4]`; word within vreg = `addr_i[3:2]`. Word 0 holds vector bits [31:0].
- Hit: `addr_i[AddrWidth-1:9] == VrfStartAddr` and `addr_i[1:0] == 2'b00`.
- Grant: `gnt_o = req_i & ~clear_i`, combinational. No other stall source.
- Accepted write hit: bytes with `be_i[k]=1` update `mem[idx][8k+7:8k]` at the clock edge. Other bytes are unchanged. `be_i = 0` is legal and performs no update.
- Accepted read hit: `mem[idx]` is sampled at the acceptance edge and driven on `rdata_o` in the response cycle.
- Miss (wrong prefix or misaligned):
  - No storage update.
  - Response has `err_o=1`, `rdata_o=0`.
- Response registers: `rvalid_q`, `err_q`, `rdata_q`. Each accepted request produces exactly one response. Responses come back in order, and at most one is outstanding.
- `clear_i=1`:
  - All words are zeroed at the edge.
  - `gnt_o=0`, so no request is accepted.
  - A response already in flight is still delivered.
- States: IDLE (`rvalid_q=0`) and RESP (`rvalid_q=1`).
  - Any state → RESP on an accepted request.
  - Any state → IDLE when no request is accepted.
  - Back-to-back requests keep the block in RESP every cycle.

## Timing
- Reset values: `rvalid_o=0`, `err_o=0`, `rdata_o=0`, all `mem` words 0. `gnt_o` follows `req_i & ~clear_i` combinationally, including during reset.
- Latency: request accepted at edge N gives its response in the cycle after edge N, for 1 cycle.
- Throughput: one request per cycle, with no bubbles.
- Read-after-write to the same word on consecutive cycles: the read returns the newly written bytes, because the write commits at the edge before the read samples.
- A read accepted in the same cycle that `clear_i` rises cannot occur, since `gnt_o=0`. A read accepted in the cycle after a clear returns 0.
- Reset mid-operation: any pending response is dropped, `rvalid_o=0` immediately, and storage returns to 0.
- Address wrap: the word index uses only `addr_i[8:2]`. The prefix check rejects anything beyond the 512-byte window; in-window addresses never alias.

## Test plan
- Reset, then read `VrfStartAddr`+0x1F0 (v31 word 0) → `gnt_o=1` same cycle; next cycle `rvalid_o=1`, `rdata_o=0`, `err_o=0`.
- Write 0xDEADBEEF with `be=4'hF` to v3 word 2 (offset 0x38), then read it on the next cycle → second response `rdata_o=0xDEADBEEF`. The write response has `rdata_o=0`, `err_o=0`.
- Partial write of 0x11223344 with `be=4'b0101` over 0xDEADBEEF at the same word, then read → `0xDE22BE44`.
- Read with prefix `VrfStartAddr+1`, and separately with address offset 0x02 → `err_o=1`, `rdata_o=0`. A subsequent read confirms storage is unchanged.
- Fill all 128 words with the value equal to their index using back-to-back writes, then read them back-to-back → 128 consecutive `rvalid_o` cycles with matching data and no gaps.
- Assert `clear_i` for 1 cycle while `req_i=1` → `gnt_o=0` that cycle. The prior in-flight response is still delivered, and the next read of any word returns 0.
